// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode/funct constants and ALU op encoding for simple_single_cpu
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_LUI = 3'd5
  } alu_op_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit ALU with zero flag
module alu
  import cpu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  output logic [31:0] o_result,
  output logic        o_zero
);

  always_comb begin
    o_result = 32'h0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {31'h0, ($signed(i_a) < $signed(i_b))};
      ALU_LUI: o_result = {i_b[15:0], 16'h0};
      default: o_result = 32'h0;
    endcase
  end

  assign o_zero = (o_result == 32'h0);

endmodule

// File: rtl/instr_memory.sv
// rtl/instr_memory.sv - word-addressed instruction ROM, contents loaded externally
module instr_memory #(
  parameter int IMEM_WORDS = 32
) (
  input  logic [31:0] i_addr,
  output logic [31:0] o_instr
);

  localparam int AW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

  reg [31:0] Instr_Mem [0:IMEM_WORDS-1];

  logic [29:0] w_idx;
  logic [1:0]  w_unused_lsb;

  assign w_idx        = i_addr[31:2];
  assign w_unused_lsb = i_addr[1:0];

  // Fetches past the end of the array return a zero word rather than aliasing.
  assign o_instr = (w_idx < 30'(IMEM_WORDS)) ? Instr_Mem[w_idx[AW-1:0]] : 32'h0;

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two combinational reads, one posedge write
module reg_file (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);

  reg [31:0] Reg_File [0:31];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) Reg_File[i] <= 32'h0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      Reg_File[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'h0 : Reg_File[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'h0 : Reg_File[i_raddr2];

endmodule

// File: rtl/simple_single_cpu.sv
// rtl/simple_single_cpu.sv - single-cycle MIPS-subset CPU top; SIMPLE_CPU_EXT_OPS_EN adds BNE/ORI/LUI
module simple_single_cpu
  import cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 32
) (
  input logic clk_i,
  input logic rst_i
);

  logic [31:0] r_pc;
  logic [31:0] w_instr, w_rs_data, w_rt_data, w_alu_b, w_alu_result;
  logic [31:0] w_imm_sext, w_pc_plus4, w_pc_next;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_waddr;
  logic [15:0] w_imm;
  logic        w_reg_we, w_use_imm, w_imm_zext, w_dst_rt;
  logic        w_is_beq, w_is_bne, w_zero, w_taken;
  logic [4:0]  w_unused_shamt;
  alu_op_e     w_alu_op;

  instr_memory #(.IMEM_WORDS(IMEM_WORDS)) IM (
    .i_addr  (r_pc),
    .o_instr (w_instr)
  );

  assign w_opcode       = w_instr[31:26];
  assign w_rs           = w_instr[25:21];
  assign w_rt           = w_instr[20:16];
  assign w_rd           = w_instr[15:11];
  assign w_unused_shamt = w_instr[10:6];
  assign w_funct        = w_instr[5:0];
  assign w_imm          = w_instr[15:0];
  assign w_imm_sext     = sext16(w_imm);

  always_comb begin
    w_reg_we   = 1'b0;
    w_use_imm  = 1'b0;
    w_imm_zext = 1'b0;
    w_dst_rt   = 1'b0;
    w_is_beq   = 1'b0;
    w_is_bne   = 1'b0;
    w_alu_op   = ALU_ADD;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD:  begin w_reg_we = 1'b1; w_alu_op = ALU_ADD; end
          FN_SUB:  begin w_reg_we = 1'b1; w_alu_op = ALU_SUB; end
          FN_AND:  begin w_reg_we = 1'b1; w_alu_op = ALU_AND; end
          FN_OR:   begin w_reg_we = 1'b1; w_alu_op = ALU_OR;  end
          FN_SLT:  begin w_reg_we = 1'b1; w_alu_op = ALU_SLT; end
          default: w_reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin w_reg_we = 1'b1; w_dst_rt = 1'b1; w_use_imm = 1'b1; w_alu_op = ALU_ADD; end
      OP_SLTI: begin w_reg_we = 1'b1; w_dst_rt = 1'b1; w_use_imm = 1'b1; w_alu_op = ALU_SLT; end
      OP_BEQ:  begin w_is_beq = 1'b1; w_alu_op = ALU_SUB; end
`ifdef SIMPLE_CPU_EXT_OPS_EN
      OP_BNE:  begin w_is_bne = 1'b1; w_alu_op = ALU_SUB; end
      OP_ORI:  begin
        w_reg_we = 1'b1; w_dst_rt = 1'b1; w_use_imm = 1'b1; w_imm_zext = 1'b1; w_alu_op = ALU_OR;
      end
      OP_LUI:  begin
        w_reg_we = 1'b1; w_dst_rt = 1'b1; w_use_imm = 1'b1; w_imm_zext = 1'b1; w_alu_op = ALU_LUI;
      end
`else
      // Extension opcodes behave exactly like any other unknown opcode here.
      OP_BNE, OP_ORI, OP_LUI: w_reg_we = 1'b0;
`endif
      default: w_reg_we = 1'b0;
    endcase
  end

  assign w_waddr = w_dst_rt ? w_rt : w_rd;

  reg_file RF (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_we     (w_reg_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_alu_result),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rs_data),
    .o_rdata2 (w_rt_data)
  );

  assign w_alu_b = w_use_imm ? (w_imm_zext ? {16'h0, w_imm} : w_imm_sext) : w_rt_data;

  alu u_alu (
    .i_a      (w_rs_data),
    .i_b      (w_alu_b),
    .i_op     (w_alu_op),
    .o_result (w_alu_result),
    .o_zero   (w_zero)
  );

  assign w_taken    = (w_is_beq & w_zero) | (w_is_bne & ~w_zero);
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_next  = w_taken ? (w_pc_plus4 + {w_imm_sext[29:0], 2'b00}) : w_pc_plus4;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_pc <= 32'h0;
    else       r_pc <= w_pc_next;
  end

endmodule

// File: tb/tb_simple_single_cpu.sv
// tb/tb_simple_single_cpu.sv - scoreboard bench for simple_single_cpu (honours SIMPLE_CPU_EXT_OPS_EN)
module tb_simple_single_cpu;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  simple_single_cpu #(.IMEM_WORDS(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i)
  );

  typedef struct {
    bit          is_pc;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] prog [0:31];

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  localparam logic [31:0] HALT = {6'h04, 5'd0, 5'd0, 16'hFFFF};

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 32'h0;
  endtask

  task automatic run_prog(input int cycles);
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) dut.IM.Instr_Mem[i] = prog[i];
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (cycles) @(posedge clk_i);
    #1;
  endtask

  task automatic exp_reg(input int idx, input logic [31:0] v);
    exp_t e;
    e.is_pc = 1'b0; e.idx = idx; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_pc(input logic [31:0] v);
    exp_t e;
    e.is_pc = 1'b1; e.idx = -1; e.val = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk_i);
      budget--;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compares architectural state on the falling edge, away from updates.
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = e.is_pc ? dut.r_pc : dut.RF.Reg_File[e.idx];
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        if (e.is_pc) $display("FAIL pc: got 0x%08h, required 0x%08h", act, e.val);
        else         $display("FAIL reg$%0d: got 0x%08h, required 0x%08h", e.idx, act, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    // ALU ops, immediates, $0 write, wrap-around, unknown words
    clear_prog();
    prog[0]  = i_ins(6'h08, 1, 0, 5);
    prog[1]  = i_ins(6'h08, 2, 0, -3);
    prog[2]  = r_ins(6'h20, 3, 1, 2);
    prog[3]  = r_ins(6'h22, 4, 1, 2);
    prog[4]  = r_ins(6'h24, 5, 1, 2);
    prog[5]  = r_ins(6'h25, 6, 1, 2);
    prog[6]  = r_ins(6'h2A, 7, 2, 1);
    prog[7]  = i_ins(6'h0A, 8, 1, -1);
    prog[8]  = i_ins(6'h08, 0, 0, 7);
    prog[9]  = i_ins(6'h08, 10, 0, -1);
    prog[10] = r_ins(6'h20, 11, 10, 10);
    prog[11] = 32'h0000_0000;
    prog[12] = 32'hFC00_0000 | {5'd0, 5'd1, 16'h1234};
    prog[13] = r_ins(6'h3F, 13, 1, 1);
    prog[14] = HALT;
    run_prog(25);
    exp_pc(32'd56);
    exp_reg(1,  32'h0000_0005);
    exp_reg(2,  32'hFFFF_FFFD);
    exp_reg(3,  32'h0000_0002);
    exp_reg(4,  32'h0000_0008);
    exp_reg(5,  32'h0000_0005);
    exp_reg(6,  32'hFFFF_FFFD);
    exp_reg(7,  32'h0000_0001);
    exp_reg(8,  32'h0000_0000);
    exp_reg(0,  32'h0000_0000);
    exp_reg(10, 32'hFFFF_FFFF);
    exp_reg(11, 32'hFFFF_FFFE);
    exp_reg(13, 32'h0000_0000);
    drain();

    // Reset after activity clears PC and every register
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    exp_pc(32'h0);
    for (int i = 0; i < 32; i++) exp_reg(i, 32'h0);
    drain();

    // Countdown loop with backward beq, then a taken forward beq
    clear_prog();
    prog[0] = i_ins(6'h08, 13, 0, 4);
    prog[1] = i_ins(6'h08, 14, 0, 0);
    prog[2] = i_ins(6'h04, 0, 13, 3);
    prog[3] = i_ins(6'h08, 13, 13, -1);
    prog[4] = i_ins(6'h08, 14, 14, 1);
    prog[5] = i_ins(6'h04, 0, 0, -4);
    prog[6] = i_ins(6'h04, 1, 1, 1);
    prog[7] = i_ins(6'h08, 9, 0, 1);
    prog[8] = i_ins(6'h08, 15, 0, 16'h77);
    prog[9] = HALT;
    run_prog(40);
    exp_pc(32'd36);
    exp_reg(13, 32'h0);
    exp_reg(14, 32'h4);
    exp_reg(9,  32'h0);
    exp_reg(15, 32'h77);
    drain();

    // Extension opcodes: LUI/ORI/BNE
    clear_prog();
    prog[0] = i_ins(6'h0F, 12, 0, 16'h1234);
    prog[1] = i_ins(6'h0D, 12, 12, 16'h5678);
    prog[2] = i_ins(6'h08, 16, 0, 3);
    prog[3] = i_ins(6'h05, 0, 16, 1);
    prog[4] = i_ins(6'h08, 17, 0, 1);
    prog[5] = i_ins(6'h08, 18, 0, 2);
    prog[6] = HALT;
    run_prog(15);
    exp_pc(32'd24);
`ifdef SIMPLE_CPU_EXT_OPS_EN
    exp_reg(12, 32'h1234_5678);
    exp_reg(17, 32'h0);
`else
    exp_reg(12, 32'h0);
    exp_reg(17, 32'h1);
`endif
    exp_reg(16, 32'h3);
    exp_reg(18, 32'h2);
    drain();

    // Fetch beyond the last word reads zero instead of aliasing into the array
    clear_prog();
    prog[0] = i_ins(6'h04, 0, 0, 40);
    prog[9] = i_ins(6'h08, 20, 0, 9);
    run_prog(3);
    exp_pc(32'd172);
    exp_reg(20, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
